// File: rtl/ws2811_encoder_pkg.sv
// Shared timing defaults and types for the WS2811 line encoder.
// The constants mirror the decoder's so both ends agree on bit and reset timing.
package ws2811_encoder_pkg;

    localparam int K800_CYC    = 50;    // 1.25 us bit period at 40 MHz
    localparam int K_T1H_CYC   = 24;    // 600 ns high time for a '1'
    localparam int K_T0H_CYC   = 10;    // 250 ns high time for a '0'
    localparam int K_RESET_CYC = 2000;  // 50 us end-of-frame low, longer than the decoder's

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESET
    } encState_t;

    // One counter serves both the bit period and the frame reset, so size it for the longer one.
    function automatic int cycWidth(input int bitCyc, input int resetCyc);
        return $clog2((bitCyc > resetCyc) ? bitCyc : resetCyc);
    endfunction

endpackage

// File: rtl/ws2811_encoder_if.sv
// Byte stream handshake into the WS2811 encoder: one byte per accept, with an end-of-frame flag.
interface ws2811_encoder_if;

    logic [7:0] dataIn;
    logic       dataLast;
    logic       dataValid;
    logic       dataReady;

    modport master (
        output dataIn,
        output dataLast,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataIn,
        input  dataLast,
        input  dataValid,
        output dataReady
    );

endinterface

// File: rtl/ws2811_encoder_bit_timer.sv
// Cycle counter and pulse-width compare for the WS2811 line; the FSM tells it when to
// restart or count, and whether the current period carries a pulse.
module ws2811_encoder_bit_timer
    import ws2811_encoder_pkg::*;
#(
    parameter int BIT_CYC   = K800_CYC,
    parameter int T1H_CYC   = K_T1H_CYC,
    parameter int T0H_CYC   = K_T0H_CYC,
    parameter int RESET_CYC = K_RESET_CYC,
    parameter int CYC_W     = cycWidth(BIT_CYC, RESET_CYC)
) (
    input  logic masterClk,
    input  logic nReset,
    input  logic restart,
    input  logic count,
    input  logic pulse,
    input  logic bitVal,
    output logic dataOut,
    output logic bitDone,
    output logic resetDone
);

    localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] RESET_LAST = CYC_W'(RESET_CYC - 1);
    localparam logic [CYC_W-1:0] T1H_LEN    = CYC_W'(T1H_CYC);
    localparam logic [CYC_W-1:0] T0H_LEN    = CYC_W'(T0H_CYC);

    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cycNext;
    logic [CYC_W-1:0] highLen;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cycNext = cyc;
        if (restart) begin
            cycNext = '0;
        end else if (count) begin
            cycNext = cyc + 1'b1;
        end
    end

    assign highLen = bitVal ? T1H_LEN : T0H_LEN;

    // The line is registered from the next count, so a bit starting on this edge is high immediately.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            cyc     <= '0;
            dataOut <= 1'b0;
        end else begin
            cyc     <= cycNext;
            dataOut <= pulse && (cycNext < highLen);
        end
    end

    assign bitDone   = (cyc == BIT_LAST);
    assign resetDone = (cyc == RESET_LAST);

endmodule

// File: rtl/ws2811_encoder.sv
// WS2811 transmitter: bytes from a valid/ready stream become 800 kbps pulse-width bits, MSB first,
// with a long low reset period closing each frame.
module ws2811_encoder
    import ws2811_encoder_pkg::*;
#(
    parameter int BIT_CYC   = K800_CYC,
    parameter int T1H_CYC   = K_T1H_CYC,
    parameter int T0H_CYC   = K_T0H_CYC,
    parameter int RESET_CYC = K_RESET_CYC
) (
    input  logic            masterClk,
    input  logic            nReset,
    ws2811_encoder_if.slave bus,
    output logic            dataOut,
    output logic            busy,
    output logic            underrun
);

    localparam int CYC_W = cycWidth(BIT_CYC, RESET_CYC);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : gBadPulse
        $error("ws2811_encoder: pulse widths must satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC");
    end
    if (!(RESET_CYC > BIT_CYC)) begin : gBadReset
        $error("ws2811_encoder: RESET_CYC must exceed BIT_CYC");
    end

    encState_t  state;
    encState_t  stateNext;
    logic       holdFull;
    logic [7:0] holdData;
    logic       holdLast;
    logic [7:0] shifter;
    logic       shLast;
    logic [2:0] bitCnt;

    logic accept;
    logic load;
    logic shift;
    logic underrunNext;
    logic restart;
    logic count;
    logic pulse;
    logic bitVal;
    logic bitDone;
    logic resetDone;

    assign bus.dataReady = !holdFull;
    assign accept        = bus.dataValid && !holdFull;
    assign busy          = (state != ST_IDLE) || holdFull;

    always_comb begin
        stateNext    = state;
        load         = 1'b0;
        shift        = 1'b0;
        underrunNext = 1'b0;
        restart      = 1'b0;
        count        = 1'b0;
        pulse        = 1'b0;
        bitVal       = shifter[7];
        unique case (state)
            ST_IDLE: begin
                if (holdFull) begin
                    load      = 1'b1;
                    restart   = 1'b1;
                    pulse     = 1'b1;
                    bitVal    = holdData[7];
                    stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!bitDone) begin
                    count = 1'b1;
                    pulse = 1'b1;
                end else if (bitCnt != 3'd7) begin
                    shift   = 1'b1;
                    restart = 1'b1;
                    pulse   = 1'b1;
                    bitVal  = shifter[6];
                end else if (shLast) begin
                    restart   = 1'b1;
                    stateNext = ST_RESET;
                end else if (holdFull) begin
                    // Chain straight into the next byte with no idle cycle on the line.
                    load    = 1'b1;
                    restart = 1'b1;
                    pulse   = 1'b1;
                    bitVal  = holdData[7];
                end else begin
                    underrunNext = 1'b1;
                    restart      = 1'b1;
                    stateNext    = ST_IDLE;
                end
            end
            ST_RESET: begin
                if (resetDone) begin
                    restart   = 1'b1;
                    stateNext = ST_IDLE;
                end else begin
                    count = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so a mid-frame reset discards the held byte cleanly.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            holdFull <= 1'b0;
            holdData <= '0;
            holdLast <= 1'b0;
            shifter  <= '0;
            shLast   <= 1'b0;
            bitCnt   <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= stateNext;
            underrun <= underrunNext;
            if (accept) begin
                holdFull <= 1'b1;
                holdData <= bus.dataIn;
                holdLast <= bus.dataLast;
            end else if (load) begin
                holdFull <= 1'b0;
            end
            if (load) begin
                shifter <= holdData;
                shLast  <= holdLast;
                bitCnt  <= '0;
            end else if (shift) begin
                shifter <= {shifter[6:0], 1'b0};
                bitCnt  <= bitCnt + 3'd1;
            end
        end
    end

    ws2811_encoder_bit_timer #(
        .BIT_CYC   (BIT_CYC),
        .T1H_CYC   (T1H_CYC),
        .T0H_CYC   (T0H_CYC),
        .RESET_CYC (RESET_CYC),
        .CYC_W     (CYC_W)
    ) uTimer (
        .masterClk (masterClk),
        .nReset    (nReset),
        .restart   (restart),
        .count     (count),
        .pulse     (pulse),
        .bitVal    (bitVal),
        .dataOut   (dataOut),
        .bitDone   (bitDone),
        .resetDone (resetDone)
    );

endmodule

// File: tb/tb_ws2811_encoder.sv
// Scoreboard bench for ws2811_encoder: stimulus queues the expected pulse for every bit sent,
// and a line monitor measures each pulse and compares it against the queue.
`timescale 1ns/100ps
module tb_ws2811_encoder;

    typedef struct {
        int highLen;
        bit contig;
        int expLow;
    } bitExp_t;

    logic masterClk = 1'b0;
    logic nReset    = 1'b0;
    logic dataOut;
    logic busy;
    logic underrun;

    ws2811_encoder_if bus();

    ws2811_encoder dut (
        .masterClk (masterClk),
        .nReset    (nReset),
        .bus       (bus),
        .dataOut   (dataOut),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #12.5 masterClk = ~masterClk;

    int      nVec = 0;
    int      nErr = 0;
    bitExp_t expQ[$];
    bitExp_t cur;
    bit      curValid;
    int      hiCnt, loCnt, sinceRise, riseCnt;
    int      urCnt, urSamples, underrunLow, busyFallLow;
    logic    prevOut, prevBusy, prevUr;

    task automatic check(input string name, input int actual, input int expected);
        nVec++;
        if (actual !== expected) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Line monitor, sampling mid-cycle on the falling edge.
    always @(negedge masterClk) begin
        if (!nReset) begin
            hiCnt = 0; loCnt = 0; sinceRise = 0; curValid = 0;
            prevOut = 1'b0; prevBusy = 1'b0; prevUr = 1'b0;
        end else begin
            if (dataOut && !prevOut) begin
                check("pulse expected", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    cur = expQ.pop_front();
                    curValid = 1;
                    if (cur.contig) check("bit period", sinceRise, 50);
                    if (cur.expLow > 0) check("low gap before frame", loCnt, cur.expLow);
                end
                riseCnt++;
                hiCnt = 0;
                sinceRise = 0;
            end else if (!dataOut && prevOut) begin
                if (curValid) check("high pulse width", hiCnt, cur.highLen);
                curValid = 0;
                loCnt = 0;
            end
            if (underrun && !prevUr) begin
                underrunLow = loCnt;
                urCnt++;
            end
            if (underrun) urSamples++;
            if (!busy && prevBusy) busyFallLow = loCnt;
            if (dataOut) hiCnt++;
            else loCnt++;
            sinceRise++;
            prevOut  = dataOut;
            prevBusy = busy;
            prevUr   = underrun;
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic last, input bit contig0,
                            input int expLow0, output int waitCyc);
        bitExp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.highLen = b[i] ? 24 : 10;
            e.contig  = (i == 7) ? contig0 : 1'b1;
            e.expLow  = (i == 7) ? expLow0 : 0;
            expQ.push_back(e);
        end
        @(negedge masterClk);
        bus.dataIn    = b;
        bus.dataLast  = last;
        bus.dataValid = 1'b1;
        waitCyc = 0;
        while (!bus.dataReady && waitCyc < 3000) begin
            @(negedge masterClk);
            waitCyc++;
        end
        check("dataReady before accept", bus.dataReady, 1);
        @(negedge masterClk);
        bus.dataValid = 1'b0;
        check("dataReady low after accept", bus.dataReady, 0);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge masterClk);
            n++;
        end
        check("busy clears", busy, 0);
        repeat (3) @(negedge masterClk);
    endtask

    initial begin
        int w, n, r0, c0, u0;
        logic [7:0] b;

        bus.dataIn    = '0;
        bus.dataLast  = 1'b0;
        bus.dataValid = 1'b0;
        nReset        = 1'b0;
        repeat (3) @(negedge masterClk);
        check("reset dataOut", dataOut, 0);
        check("reset dataReady", bus.dataReady, 1);
        check("reset busy", busy, 0);
        check("reset underrun", underrun, 0);
        nReset = 1'b1;

        // Single byte 0xA5 closing a frame.
        sendByte(8'hA5, 1'b1, 1'b0, 0, w);
        @(negedge masterClk);
        check("dataReady after load", bus.dataReady, 1);
        check("first bit high", dataOut, 1);
        check("busy while shifting", busy, 1);
        waitIdle();
        check("A5 trailing low + reset length", busyFallLow, 26 + 2000);
        check("line idle after A5", dataOut, 0);

        // 0xFF then 0x00 back to back: sixteen contiguous bits.
        sendByte(8'hFF, 1'b0, 1'b0, 0, w);
        sendByte(8'h00, 1'b1, 1'b1, 0, w);
        waitIdle();
        check("00 trailing low + reset length", busyFallLow, 40 + 2000);

        // Lone 0x80 without last flag: underrun.
        c0 = urCnt;
        u0 = urSamples;
        sendByte(8'h80, 1'b0, 1'b0, 0, w);
        waitIdle();
        check("underrun pulses", urCnt - c0, 1);
        check("underrun width", urSamples - u0, 1);
        check("underrun after last bit", underrunLow, 40);
        check("line low after underrun", dataOut, 0);
        check("dataReady after underrun", bus.dataReady, 1);

        // Reset at cycle 5 of a '1' bit with a byte held.
        c0 = urCnt;
        sendByte(8'hFF, 1'b0, 1'b0, 0, w);
        sendByte(8'h55, 1'b1, 1'b1, 0, w);
        r0 = riseCnt;
        n  = 0;
        while (riseCnt == r0 && n < 200) begin
            @(negedge masterClk);
            n++;
        end
        check("second bit started", riseCnt - r0, 1);
        repeat (5) @(negedge masterClk);
        #2 nReset = 1'b0;
        #1;
        check("mid-bit reset dataOut", dataOut, 0);
        check("mid-bit reset dataReady", bus.dataReady, 1);
        check("mid-bit reset busy", busy, 0);
        check("mid-bit reset underrun", underrun, 0);
        expQ.delete();
        repeat (3) @(negedge masterClk);
        nReset = 1'b1;
        repeat (100) @(negedge masterClk);
        check("no underrun from reset", urCnt - c0, 0);
        check("idle after reset", busy, 0);
        sendByte(8'h3C, 1'b1, 1'b0, 0, w);
        waitIdle();
        check("3C trailing low + reset length", busyFallLow, 40 + 2000);

        // Byte offered while the frame reset is running.
        sendByte(8'hA5, 1'b1, 1'b0, 0, w);
        r0 = riseCnt;
        n  = 0;
        while (riseCnt - r0 < 8 && n < 1000) begin
            @(negedge masterClk);
            n++;
        end
        check("A5 bits seen", riseCnt - r0, 8);
        repeat (100) @(negedge masterClk);
        check("busy during reset", busy, 1);
        check("dataReady during reset", bus.dataReady, 1);
        sendByte(8'h3C, 1'b1, 1'b0, 26 + 2000 + 1, w);
        check("accept without wait during reset", w, 0);
        waitIdle();

        // 24-byte frame of mixed data, all bytes chained.
        for (int i = 0; i < 24; i++) begin
            b = 8'(i * 37 + 11);
            sendByte(b, (i == 23), (i != 0), 0, w);
        end
        waitIdle();

        check("all expected bits seen", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
